// File: rtl/c432_irq_pkg.sv
// Shared types for the c432 interrupt capture block: field widths, detect FSM states
// and the queued event record.
package c432_irq_pkg;

  localparam int unsigned GRP_W  = 3;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } irq_state_e;

  typedef struct packed {
    logic [GRP_W-1:0]  grp;
    logic [CODE_W-1:0] code;
  } irq_evt_t;

endpackage

// File: rtl/c432_irq_capture_if.sv
// Consumer-side valid/ready event channel of the c432 interrupt capture block.
interface c432_irq_capture_if;
  import c432_irq_pkg::*;

  logic              irq_vld;
  logic              irq_rdy;
  logic [GRP_W-1:0]  irq_grp;
  logic [CODE_W-1:0] irq_code;

  modport master (
    output irq_vld,
    output irq_grp,
    output irq_code,
    input  irq_rdy
  );

  modport slave (
    input  irq_vld,
    input  irq_grp,
    input  irq_code,
    output irq_rdy
  );

endinterface

// File: rtl/c432_irq_fifo.sv
// Event FIFO with wrap-bit pointers so occupancy covers 0..DEPTH; head reads as zero when
// empty and a push into a full FIFO is taken when a pop happens in the same cycle.
module c432_irq_fifo
  import c432_irq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  irq_evt_t wdata,
  input  logic     pop,
  output irq_evt_t rdata,
  output logic     full,
  output logic     empty,
  output logic [AW:0] lvl
);

  irq_evt_t    mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  always_comb begin
    lvl     = wr_ptr_q - rd_ptr_q;
    full    = (lvl == (AW+1)'(DEPTH));
    empty   = (lvl == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rdata   = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; pointer reset is what flushes queued events.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/c432_irq_capture.sv
// Captures c432 encoder outputs through two register stages, queues each new nonzero
// {grp,code} as an event and counts events lost to FIFO overflow.
module c432_irq_capture
  import c432_irq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [GRP_W-1:0]       enc_grp,
  input  logic [CODE_W-1:0]      enc_code,
  c432_irq_capture_if.master     irq,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [$clog2(DEPTH):0] fifo_lvl
);

  irq_evt_t   s1_q, s2_q, last_q, last_d;
  irq_state_e state_q, state_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic       push, pop, full, empty, drop;
  irq_evt_t   head;
  logic [$clog2(DEPTH):0] lvl;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (s2_q.grp != '0) begin
          push    = 1'b1;
          last_d  = s2_q;
          state_d = StActive;
        end
      end
      StActive: begin
        if (s2_q.grp == '0) begin
          state_d = StIdle;
        end else if (s2_q != last_q) begin
          push   = 1'b1;
          last_d = s2_q;
        end
      end
    endcase
  end

  // Outputs are forced low while reset is asserted, even before the first reset edge.
  always_comb begin
    irq.irq_vld  = rst_n && !empty;
    irq.irq_grp  = rst_n ? head.grp  : '0;
    irq.irq_code = rst_n ? head.code : '0;
    fifo_lvl     = rst_n ? lvl : '0;
    pop          = irq.irq_vld && irq.irq_rdy;
    drop         = push && full && !pop;
    drop_cnt_d   = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    drop_cnt     = drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      last_q     <= '0;
      state_q    <= StIdle;
      drop_cnt_q <= '0;
    end else begin
      s1_q       <= '{grp: enc_grp, code: enc_code};
      s2_q       <= s1_q;
      last_q     <= last_d;
      state_q    <= state_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  c432_irq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (s2_q),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .lvl   (lvl)
  );

endmodule

// File: tb/tb_c432_irq_capture.sv
// Directed self-checking bench for c432_irq_capture (DEPTH=4, CNT_W=8).
module tb_c432_irq_capture;
  import c432_irq_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [GRP_W-1:0]  enc_grp;
  logic [CODE_W-1:0] enc_code;
  logic [7:0]        drop_cnt;
  logic [2:0]        fifo_lvl;
  int                checks;
  int                errors;

  c432_irq_capture_if irq_bus ();

  c432_irq_capture #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enc_grp  (enc_grp),
    .enc_code (enc_code),
    .irq      (irq_bus),
    .drop_cnt (drop_cnt),
    .fifo_lvl (fifo_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int g, input int c, input int n);
    enc_grp  = GRP_W'(g);
    enc_code = CODE_W'(c);
    repeat (n) step();
  endtask

  task automatic idle(input int n);
    drive(0, 0, n);
  endtask

  task automatic pop_check(input string tag, input int g, input int c);
    chk({tag, "_vld"}, 32'(irq_bus.irq_vld), 32'd1);
    chk({tag, "_grp"}, 32'(irq_bus.irq_grp), 32'(g));
    chk({tag, "_code"}, 32'(irq_bus.irq_code), 32'(c));
    irq_bus.irq_rdy = 1'b1;
    step();
    irq_bus.irq_rdy = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    enc_grp = '0;
    enc_code = '0;
    irq_bus.irq_rdy = 1'b0;

    // Outputs low during reset, before and after reset edges
    #1;
    chk("rst_pre_vld", 32'(irq_bus.irq_vld), 32'd0);
    chk("rst_pre_lvl", 32'(fifo_lvl), 32'd0);
    step();
    step();
    chk("rst_vld", 32'(irq_bus.irq_vld), 32'd0);
    chk("rst_grp", 32'(irq_bus.irq_grp), 32'd0);
    chk("rst_code", 32'(irq_bus.irq_code), 32'd0);
    chk("rst_lvl", 32'(fifo_lvl), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;

    // Latency: {1,A} held, consumer always ready
    enc_grp = 3'd1;
    enc_code = 4'hA;
    irq_bus.irq_rdy = 1'b1;
    step();
    chk("lat_e1_vld", 32'(irq_bus.irq_vld), 32'd0);
    step();
    chk("lat_e2_vld", 32'(irq_bus.irq_vld), 32'd0);
    step();
    chk("lat_e3_vld", 32'(irq_bus.irq_vld), 32'd1);
    chk("lat_e3_grp", 32'(irq_bus.irq_grp), 32'd1);
    chk("lat_e3_code", 32'(irq_bus.irq_code), 32'hA);
    step();
    chk("lat_e4_vld", 32'(irq_bus.irq_vld), 32'd0);
    chk("lat_e4_grp", 32'(irq_bus.irq_grp), 32'd0);
    step();
    step();
    chk("lat_e6_vld", 32'(irq_bus.irq_vld), 32'd0);
    chk("lat_e6_lvl", 32'(fifo_lvl), 32'd0);
    irq_bus.irq_rdy = 1'b0;
    idle(4);

    // Change detect
    drive(1, 'hA, 5);
    drive(3, 5, 5);
    idle(4);
    chk("chg_lvl", 32'(fifo_lvl), 32'd2);
    pop_check("chg_h0", 1, 'hA);
    pop_check("chg_h1", 3, 5);
    chk("chg_empty_vld", 32'(irq_bus.irq_vld), 32'd0);

    // Re-arm after a one-cycle gap
    drive(1, 'hA, 1);
    idle(1);
    drive(1, 'hA, 1);
    idle(4);
    chk("rearm_lvl", 32'(fifo_lvl), 32'd2);
    pop_check("rearm_h0", 1, 'hA);
    pop_check("rearm_h1", 1, 'hA);
    chk("rearm_empty_lvl", 32'(fifo_lvl), 32'd0);

    // Overflow: six distinct events into a depth-4 FIFO
    for (int i = 1; i <= 6; i++) drive(i, i, 1);
    idle(4);
    chk("ovf_lvl", 32'(fifo_lvl), 32'd4);
    chk("ovf_drop", 32'(drop_cnt), 32'd2);
    chk("ovf_head_grp", 32'(irq_bus.irq_grp), 32'd1);

    // Full with push and pop on the same edge
    drive(7, 7, 1);
    idle(1);
    irq_bus.irq_rdy = 1'b1;
    step();
    irq_bus.irq_rdy = 1'b0;
    chk("fpp_lvl", 32'(fifo_lvl), 32'd4);
    chk("fpp_drop", 32'(drop_cnt), 32'd2);
    idle(3);
    pop_check("fpp_h0", 2, 2);
    pop_check("fpp_h1", 3, 3);
    pop_check("fpp_h2", 4, 4);
    pop_check("fpp_h3", 7, 7);
    chk("fpp_empty_vld", 32'(irq_bus.irq_vld), 32'd0);
    chk("fpp_empty_lvl", 32'(fifo_lvl), 32'd0);

    // Drop counter saturation: 304 pushes, 4 kept, 300 lost
    for (int i = 0; i < 304; i++) drive((i % 2 == 1) ? 2 : 1, 0, 1);
    idle(4);
    chk("sat_lvl", 32'(fifo_lvl), 32'd4);
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    rst_n = 1'b0;
    #1;
    chk("sat_rst_vld", 32'(irq_bus.irq_vld), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("sat_rst_drop", 32'(drop_cnt), 32'd0);
    chk("sat_rst_lvl", 32'(fifo_lvl), 32'd0);

    // Mid-run reset flushes queue; post-reset latency is three edges
    drive(1, 1, 1);
    drive(2, 2, 1);
    drive(3, 3, 1);
    idle(4);
    chk("mrr_pre_lvl", 32'(fifo_lvl), 32'd3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrr_vld", 32'(irq_bus.irq_vld), 32'd0);
    chk("mrr_lvl", 32'(fifo_lvl), 32'd0);
    chk("mrr_drop", 32'(drop_cnt), 32'd0);
    enc_grp = 3'd5;
    enc_code = 4'd9;
    step();
    chk("mrr_e1_vld", 32'(irq_bus.irq_vld), 32'd0);
    step();
    chk("mrr_e2_vld", 32'(irq_bus.irq_vld), 32'd0);
    step();
    chk("mrr_e3_vld", 32'(irq_bus.irq_vld), 32'd1);
    chk("mrr_e3_grp", 32'(irq_bus.irq_grp), 32'd5);
    chk("mrr_e3_code", 32'(irq_bus.irq_code), 32'd9);
    chk("mrr_e3_lvl", 32'(fifo_lvl), 32'd1);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
